seg_page_scheduler: RTL and testbench

Page scheduler that sits in front of the four-digit seven-segment cathode driver and decides which 16-bit value the display shows. Holds up to four MCU-written pages, rotates through the valid ones on a dwell timer, and grants a priority override source exclusive use of the display. Its HEX output feeds the cathode driver's 16-bit HEX input.

---
 rtl/seg_page_scheduler.sv | 180 ++++++++++++++++++
 tb/tb_seg_page_scheduler.sv | 167 ++++++++++++++++
 2 files changed

// File: rtl/seg_page_scheduler.sv
// seg_page_scheduler: selects the 16-bit value shown by the seven-segment
// cathode driver. Rotates through up to four MCU-written pages on a dwell
// timer and grants a priority override source exclusive use of the display.
//
// Ports:
//   CLK, RST_N      clock, asynchronous active-low reset
//   WR_EN/WR_ADDR/WR_DATA  page write (sets valid bit)
//   CLR_EN          invalidate page WR_ADDR (data kept; write wins on clash)
//   OVR_REQ/OVR_DATA  override request (level) and value
//   OVR_GNT         override active
//   HEX             value to the cathode driver
//   BLANK           nothing to show
//   CUR_PAGE        selected page index
//   PAGE_VALID      per-page valid bits
module seg_page_scheduler #(
   parameter int unsigned DWELL_CYCLES    = 100_000_000,
   parameter int unsigned OVR_HOLD_CYCLES = 50_000_000
) (
   input  logic        CLK,
   input  logic        RST_N,
   input  logic        WR_EN,
   input  logic [1:0]  WR_ADDR,
   input  logic [15:0] WR_DATA,
   input  logic        CLR_EN,
   input  logic        OVR_REQ,
   input  logic [15:0] OVR_DATA,
   output logic        OVR_GNT,
   output logic [15:0] HEX,
   output logic        BLANK,
   output logic [1:0]  CUR_PAGE,
   output logic [3:0]  PAGE_VALID
);

   localparam int unsigned NUM_PAGES = 4;
   localparam int unsigned DATA_W    = 16;
   localparam int unsigned CNT_W     = 32;
   localparam logic [CNT_W-1:0] DWELL_LAST = CNT_W'(DWELL_CYCLES - 1);
   localparam logic [CNT_W-1:0] HOLD_LAST  = CNT_W'(OVR_HOLD_CYCLES - 1);

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      SHOW     = 2'd1,
      OVERRIDE = 2'd2
   } state_t;

   state_t                          state_q, state_n;
   logic [NUM_PAGES-1:0][DATA_W-1:0] pages_q, pages_n;
   logic [NUM_PAGES-1:0]            valid_q, valid_n;
   logic [1:0]                      cur_q, cur_n;
   logic [CNT_W-1:0]                dwell_q, dwell_n;
   logic [CNT_W-1:0]                hold_q, hold_n;
   logic [DATA_W-1:0]               hex_n;
   logic                            blank_n, gnt_n;
   logic [2:0]                      nxt;   // {found, index}
   logic [1:0]                      low;

   // Next valid page searching upward from cur+1; cur itself is the last candidate.
   function automatic logic [2:0] next_valid(input logic [3:0] v, input logic [1:0] cur);
      logic [2:0] r;
      logic [1:0] idx;
      r = 3'b000;
      for (int i = 4; i >= 1; i--) begin
         idx = cur + 2'(i);
         if (v[idx]) r = {1'b1, idx};
      end
      return r;
   endfunction

   // Lowest-index valid page.
   function automatic logic [1:0] lowest_valid(input logic [3:0] v);
      logic [1:0] r;
      r = 2'd0;
      for (int i = 3; i >= 0; i--) begin
         if (v[i]) r = 2'(i);
      end
      return r;
   endfunction

   // State and datapath registers.
   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         state_q    <= IDLE;
         pages_q    <= '0;
         valid_q    <= '0;
         cur_q      <= '0;
         dwell_q    <= '0;
         hold_q     <= '0;
         HEX        <= '0;
         BLANK      <= 1'b1;
         OVR_GNT    <= 1'b0;
      end else begin
         state_q    <= state_n;
         pages_q    <= pages_n;
         valid_q    <= valid_n;
         cur_q      <= cur_n;
         dwell_q    <= dwell_n;
         hold_q     <= hold_n;
         HEX        <= hex_n;
         BLANK      <= blank_n;
         OVR_GNT    <= gnt_n;
      end
   end

   assign CUR_PAGE   = cur_q;
   assign PAGE_VALID = valid_q;

   // Next-state, page store update and output decode.
   always_comb begin
      state_n = state_q;
      pages_n = pages_q;
      valid_n = valid_q;
      cur_n   = cur_q;
      dwell_n = dwell_q;
      hold_n  = hold_q;
      nxt     = next_valid(valid_q, cur_q);
      low     = lowest_valid(valid_q);

      // Clear first so a same-address write wins.
      if (CLR_EN) valid_n[WR_ADDR] = 1'b0;
      if (WR_EN) begin
         pages_n[WR_ADDR] = WR_DATA;
         valid_n[WR_ADDR] = 1'b1;
      end

      case (state_q)
         IDLE: begin
            if (OVR_REQ) begin
               state_n = OVERRIDE;
               hold_n  = '0;
            end else if (|valid_q) begin
               state_n = SHOW;
               cur_n   = low;
               dwell_n = '0;
            end
         end
         SHOW: begin
            if (OVR_REQ) begin
               state_n = OVERRIDE;
               hold_n  = '0;
            end else if (!valid_q[cur_q]) begin
               dwell_n = '0;
               if (nxt[2]) cur_n = nxt[1:0];
               else        state_n = IDLE;
            end else if (dwell_q == DWELL_LAST) begin
               dwell_n = '0;
               cur_n   = nxt[1:0];
            end else begin
               dwell_n = dwell_q + CNT_W'(1);
            end
         end
         OVERRIDE: begin
            if (!OVR_REQ && (hold_q >= HOLD_LAST)) begin
               dwell_n = '0;
               if (valid_q[cur_q]) begin
                  state_n = SHOW;
               end else if (nxt[2]) begin
                  state_n = SHOW;
                  cur_n   = nxt[1:0];
               end else begin
                  state_n = IDLE;
               end
            end else if (hold_q < HOLD_LAST) begin
               // Saturate so a long-held request cannot wrap the counter.
               hold_n = hold_q + CNT_W'(1);
            end
         end
         default: state_n = IDLE;
      endcase

      // HEX follows the next page contents so writes to the shown page land in one cycle.
      case (state_n)
         SHOW:     hex_n = pages_n[cur_n];
         OVERRIDE: hex_n = OVR_DATA;
         default:  hex_n = '0;
      endcase
      blank_n = (state_n == IDLE);
      gnt_n   = (state_n == OVERRIDE);
   end

endmodule

// File: tb/tb_seg_page_scheduler.sv
// Directed bench for seg_page_scheduler with short dwell and hold times.
module tb_seg_page_scheduler;

   logic        CLK = 1'b0;
   logic        RST_N = 1'b0;
   logic        WR_EN = 1'b0;
   logic [1:0]  WR_ADDR = '0;
   logic [15:0] WR_DATA = '0;
   logic        CLR_EN = 1'b0;
   logic        OVR_REQ = 1'b0;
   logic [15:0] OVR_DATA = '0;
   logic        OVR_GNT;
   logic [15:0] HEX;
   logic        BLANK;
   logic [1:0]  CUR_PAGE;
   logic [3:0]  PAGE_VALID;

   int n_pass = 0;
   int n_total = 0;

   logic [1:0]  exp_seq [14];
   logic [15:0] page_val [4];

   seg_page_scheduler #(.DWELL_CYCLES(4), .OVR_HOLD_CYCLES(5)) dut (
      .CLK(CLK), .RST_N(RST_N),
      .WR_EN(WR_EN), .WR_ADDR(WR_ADDR), .WR_DATA(WR_DATA), .CLR_EN(CLR_EN),
      .OVR_REQ(OVR_REQ), .OVR_DATA(OVR_DATA), .OVR_GNT(OVR_GNT),
      .HEX(HEX), .BLANK(BLANK), .CUR_PAGE(CUR_PAGE), .PAGE_VALID(PAGE_VALID)
   );

   always #5 CLK = ~CLK;

   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
   endtask

   task automatic chk_reset(input string tag);
      chk({tag, "_hex"},   32'(HEX), 32'h0);
      chk({tag, "_blank"}, 32'(BLANK), 32'h1);
      chk({tag, "_cur"},   32'(CUR_PAGE), 32'h0);
      chk({tag, "_valid"}, 32'(PAGE_VALID), 32'h0);
      chk({tag, "_gnt"},   32'(OVR_GNT), 32'h0);
   endtask

   initial begin
      exp_seq  = '{2'd0, 2'd1, 2'd1, 2'd1, 2'd1, 2'd3, 2'd3, 2'd3, 2'd3,
                   2'd0, 2'd0, 2'd0, 2'd0, 2'd1};
      page_val = '{16'h1234, 16'hAAAA, 16'h0000, 16'h3333};

      // Reset state
      repeat (2) tick();
      chk_reset("rst");
      RST_N = 1'b1;

      // First page: valid bit, then selection
      WR_EN = 1'b1; WR_ADDR = 2'd0; WR_DATA = 16'h1234;
      tick();
      WR_EN = 1'b0;
      chk("wr0_valid", 32'(PAGE_VALID), 32'h1);
      chk("wr0_blank_still", 32'(BLANK), 32'h1);
      tick();
      chk("wr0_hex", 32'(HEX), 32'h1234);
      chk("wr0_blank", 32'(BLANK), 32'h0);
      chk("wr0_cur", 32'(CUR_PAGE), 32'h0);

      // Rotation over pages 0,1,3
      WR_EN = 1'b1; WR_ADDR = 2'd1; WR_DATA = 16'hAAAA;
      tick();
      WR_ADDR = 2'd3; WR_DATA = 16'h3333;
      tick();
      WR_EN = 1'b0;
      chk("rot_valid", 32'(PAGE_VALID), 32'hB);
      chk("rot_cur_start", 32'(CUR_PAGE), 32'h0);
      for (int i = 0; i < 14; i++) begin
         tick();
         chk($sformatf("rot_cur_%0d", i), 32'(CUR_PAGE), 32'(exp_seq[i]));
         chk($sformatf("rot_hex_%0d", i), 32'(HEX), 32'(page_val[exp_seq[i]]));
      end

      // Write page 2 then clear the shown page 1
      WR_EN = 1'b1; WR_ADDR = 2'd2; WR_DATA = 16'hBEEF;
      tick();
      WR_EN = 1'b0; CLR_EN = 1'b1; WR_ADDR = 2'd1;
      tick();
      CLR_EN = 1'b0;
      chk("clr_valid", 32'(PAGE_VALID), 32'hD);
      chk("clr_cur_hold", 32'(CUR_PAGE), 32'h1);
      tick();
      chk("clr_cur", 32'(CUR_PAGE), 32'h2);
      chk("clr_hex", 32'(HEX), 32'hBEEF);

      // One-cycle override pulse held for 5 cycles
      OVR_REQ = 1'b1; OVR_DATA = 16'hDEAD;
      tick();
      OVR_REQ = 1'b0;
      for (int i = 0; i < 5; i++) begin
         chk($sformatf("ovr_gnt_%0d", i), 32'(OVR_GNT), 32'h1);
         chk($sformatf("ovr_hex_%0d", i), 32'(HEX), 32'hDEAD);
         chk($sformatf("ovr_blank_%0d", i), 32'(BLANK), 32'h0);
         tick();
      end
      chk("ovr_exit_gnt", 32'(OVR_GNT), 32'h0);
      chk("ovr_exit_hex", 32'(HEX), 32'hBEEF);
      chk("ovr_exit_cur", 32'(CUR_PAGE), 32'h2);
      repeat (3) tick();
      chk("ovr_full_dwell", 32'(CUR_PAGE), 32'h2);
      tick();
      chk("ovr_next_cur", 32'(CUR_PAGE), 32'h3);
      chk("ovr_next_hex", 32'(HEX), 32'h3333);

      // Clear all pages during a held override, then release
      OVR_REQ = 1'b1; OVR_DATA = 16'h5A5A;
      tick();
      chk("ovr2_hex", 32'(HEX), 32'h5A5A);
      CLR_EN = 1'b1; WR_ADDR = 2'd0;
      tick();
      WR_ADDR = 2'd2; OVR_DATA = 16'h6B6B;
      tick();
      chk("ovr2_hex_track", 32'(HEX), 32'h6B6B);
      WR_ADDR = 2'd3;
      tick();
      CLR_EN = 1'b0;
      tick();
      chk("ovr2_held_gnt", 32'(OVR_GNT), 32'h1);
      chk("ovr2_valid", 32'(PAGE_VALID), 32'h0);
      OVR_REQ = 1'b0;
      tick();
      chk("ovr2_idle_gnt", 32'(OVR_GNT), 32'h0);
      chk("ovr2_idle_blank", 32'(BLANK), 32'h1);
      chk("ovr2_idle_hex", 32'(HEX), 32'h0);

      // Write and clear on the same address: write wins
      WR_EN = 1'b1; CLR_EN = 1'b1; WR_ADDR = 2'd1; WR_DATA = 16'h7777;
      tick();
      WR_EN = 1'b0; CLR_EN = 1'b0;
      chk("wrclr_valid", 32'(PAGE_VALID), 32'h2);
      tick();
      chk("wrclr_cur", 32'(CUR_PAGE), 32'h1);
      chk("wrclr_hex", 32'(HEX), 32'h7777);
      tick();

      // Asynchronous reset mid-dwell
      #2 RST_N = 1'b0;
      #1 chk_reset("arst");
      #1 RST_N = 1'b1;
      repeat (3) tick();
      chk("arst_blank_after", 32'(BLANK), 32'h1);
      chk("arst_hex_after", 32'(HEX), 32'h0);
      WR_EN = 1'b1; WR_ADDR = 2'd2; WR_DATA = 16'h9999;
      tick();
      WR_EN = 1'b0;
      tick();
      chk("arst_rewrite_cur", 32'(CUR_PAGE), 32'h2);
      chk("arst_rewrite_hex", 32'(HEX), 32'h9999);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
